dbus_lsu: RTL and testbench
===========================

# dbus_lsu

Parametrised load/store unit between the core execute stage and the data bus. It accepts one memory operation at a time and aligns store data and byte strobes to the bus word. It holds the bus request stable until the memory responds, then returns sign- or zero-extended load data for register writeback. It generalises the core's fixed 64-bit, doubleword-only data-bus logic to:
- configurable width;
- all RISC-V load/store sizes;
- misalignment and bus-timeout exceptions;
- a flush input.

## Interface
Parameters:
- XLEN, 64, data/register width; legal values 32 or 64.
- AW, 64, bus address width.
- TIMEOUT, 0, maximum cycles to wait for dresp_data_ok; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core presents an operation.
- req_ready  out  1  unit idle; an operation is accepted when req_valid && req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D; bit2 = unsigned (loads only).
- req_addr  in  AW  effective address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  load destination register.
- flush  in  1  cancel the writeback of the operation in flight.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  AW  request address.
- dreq_size  out  3  log2(bytes): 0, 1, 2 or 3.
- dreq_strobe  out  XLEN/8  byte enables; all zero for loads.
- dreq_data  out  XLEN  lane-shifted store data.
- dresp_data_ok  in  1  bus completion, one-cycle pulse.
- dresp_data  in  XLEN  raw read data, bus-word aligned.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  5  destination of the writeback.
- wb_data  out  XLEN  extended load result.
- done  out  1  one-cycle pulse: operation retired (load, store or exception).
- exc_valid  out  1  one-cycle pulse with done: exception.
- exc_code  out  2  1 = misaligned, 2 = illegal size, 3 = bus timeout.
- exc_addr  out  AW  faulting address.

## Operation
States:
- IDLE: req_ready = 1. On accept, latch the operation.
  - Illegal size (D or unsigned W when XLEN=32; unsigned D; any unsigned store) → EXC with code 2.
  - Otherwise misaligned address (address not a multiple of 2^size) → EXC with code 1.
  - Otherwise → BUS.
- BUS: dreq_valid = 1; dreq_addr, size, strobe and data are held constant.
  - On dresp_data_ok → RESP.
  - Otherwise, if TIMEOUT ≠ 0 and the wait counter reaches TIMEOUT → EXC with code 3.
- RESP: done = 1. For a load not flushed, wb_valid = 1. → IDLE.
- EXC: done = 1, exc_valid = 1, exc_addr = latched address. → IDLE.

Alignment rules:
- off = addr[log2(XLEN/8)-1:0].
- Store strobe = ((1 << 2^size) - 1) << off.
- Store data = req_wdata << (off*8).
- Load data = dresp_data >> (off*8), truncated to 2^size bytes, then sign-extended (bit2 = 0) or zero-extended (bit2 = 1) to XLEN.
- Load result is captured into wb_data at the cycle dresp_data_ok is seen.

Flush:
- A flush seen in any cycle of BUS, or in the accept cycle, sets a sticky cancel bit.
- The bus transaction still completes; the bus handshake is never abandoned.
- RESP then asserts done but not wb_valid.
- A flush has no effect on EXC or IDLE.

Timeout counter:
- Cleared on entry to BUS.
- Increments each BUS cycle without data_ok, saturating at TIMEOUT.
- When it expires, dreq_valid drops in the EXC cycle.

## Timing
- Reset: state IDLE; req_ready = 1; every other output 0; counter and cancel bit cleared.
- Reset mid-operation: the request is abandoned immediately, with no writeback.
- Accept at cycle N:
  - dreq_valid = 1 from N+1.
  - data_ok at cycle M ≥ N+1 gives wb_valid/done at M+1; next accept possible at M+2.
  - Minimum load/store latency: 2 cycles accept-to-done.
- Exception path: accept at N → exc_valid/done at N+1, dreq_valid never asserted.
- data_ok arriving when not in BUS is ignored.
- data_ok in the same cycle the counter expires: data_ok wins (→ RESP, no exception).
- flush together with data_ok: the writeback is suppressed.
- req_ready is 0 in BUS, RESP and EXC. The core must hold req_* until accepted.

## Test plan
- XLEN=64, load funct3=000, addr 0x80000003, bus returns 0x00000000_80000000 shifted so lane 3 = 0x80, data_ok after 3 cycles → dreq_strobe 0x00, wb_data 0xFFFFFFFFFFFFFF80, wb_valid at data_ok+1; the same with funct3=100 → 0x80.
- Store funct3=001, addr 0x1006, wdata 0xBEEF → dreq_size 1, strobe 0xC0, dreq_data 0xBEEF000000000000, done with no wb_valid.
- Load funct3=010 at addr 0x1002 → exc_valid, code 1, exc_addr 0x1002 one cycle after accept; dreq_valid stays 0.
- XLEN=32, load funct3=011 → exc code 2.
- XLEN=64, load funct3=011 at 0x2000 with data_ok after 4 cycles → the same load completes normally.
- TIMEOUT=8, data_ok never arrives → dreq_valid held 8 cycles, then exc code 3 and req_ready returns. Repeat with data_ok exactly on the expiry cycle → normal completion.
- Load with flush asserted during BUS → done pulse, no wb_valid. Separately, assert rst mid-BUS → all outputs 0 immediately and the next operation runs normally.

Source files
------------

// File: rtl/dbus_lsu.sv
// Load/store unit between execute and the data bus: one operation in flight,
// lane-aligned store data/strobes, extended load writeback, misalign/size/timeout faults.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for an operation
//   BUS    | bus request held stable until dresp_data_ok or timeout
//   RESP   | retire: done, plus wb_valid for an uncancelled load
//   EXC    | retire with exception (code/address from latched operation)
module dbus_lsu #(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [AW-1:0]     dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [XLEN/8-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              done,
    output logic              exc_valid,
    output logic [1:0]        exc_code,
    output logic [AW-1:0]     exc_addr
);
    localparam int SW = XLEN / 8;
    localparam int OW = $clog2(SW);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_EXC  = 2'd3;

    logic [1:0]      r_state;
    logic            r_store;
    logic            r_cancel;
    logic [2:0]      r_funct3;
    logic [AW-1:0]   r_addr;
    logic [4:0]      r_rd;
    logic [SW-1:0]   r_strobe;
    logic [XLEN-1:0] r_sdata;
    logic [XLEN-1:0] r_wb_data;
    logic [1:0]      r_exc_code;
    logic [CW-1:0]   r_cnt;

    logic            w_bus;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_expire;
    logic [1:0]      w_size;
    logic [OW-1:0]   w_off;
    logic [OW-1:0]   w_roff;
    logic [SW-1:0]   w_base;
    logic [SW-1:0]   w_strobe;
    logic [XLEN-1:0] w_sdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_keep;
    logic [XLEN-1:0] w_ext;
    logic            w_sign;
    logic            w_fill;

    assign w_bus    = (r_state == S_BUS);
    assign w_size   = req_funct3[1:0];
    assign w_off    = req_addr[OW-1:0];
    assign w_roff   = r_addr[OW-1:0];

    assign w_illegal = (req_store && req_funct3[2]) || (req_funct3 == 3'b111)
                     || ((XLEN == 32) && ((w_size == 2'd3) || (req_funct3 == 3'b110)));

    always_comb begin
        w_misaligned = 1'b0;
        w_base       = SW'(8'h01);
        case (w_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_base       = SW'(8'h01);
            end
            2'd1: begin
                w_misaligned = req_addr[0];
                w_base       = SW'(8'h03);
            end
            2'd2: begin
                w_misaligned = |req_addr[1:0];
                w_base       = SW'(8'h0F);
            end
            default: begin
                w_misaligned = |req_addr[2:0];
                w_base       = SW'(8'hFF);
            end
        endcase
    end

    assign w_strobe  = w_base << w_off;
    assign w_sdata   = req_wdata << {w_off, 3'b000};
    assign w_shifted = dresp_data >> {w_roff, 3'b000};

    // Keep the low 2^size bytes, fill the rest with the sign bit or zero.
    always_comb begin
        w_sign = w_shifted[XLEN-1];
        w_keep = '1;
        case (r_funct3[1:0])
            2'd0: begin
                w_sign = w_shifted[7];
                w_keep = XLEN'(8'hFF);
            end
            2'd1: begin
                w_sign = w_shifted[15];
                w_keep = XLEN'(16'hFFFF);
            end
            2'd2: begin
                w_sign = w_shifted[31];
                w_keep = XLEN'(32'hFFFF_FFFF);
            end
            default: ;
        endcase
        w_fill = w_sign & ~r_funct3[2];
        w_ext  = (w_shifted & w_keep) | ({XLEN{w_fill}} & ~w_keep);
    end

    // Expiry is decided in the last waiting cycle so the bus sees exactly TIMEOUT cycles.
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_store    <= 1'b0;
            r_cancel   <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rd       <= '0;
            r_strobe   <= '0;
            r_sdata    <= '0;
            r_wb_data  <= '0;
            r_exc_code <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_rd     <= req_rd;
                        r_strobe <= req_store ? w_strobe : '0;
                        r_sdata  <= req_store ? w_sdata : '0;
                        r_cancel <= flush;
                        r_cnt    <= '0;
                        if (w_illegal) begin
                            r_exc_code <= 2'd2;
                            r_state    <= S_EXC;
                        end else if (w_misaligned) begin
                            r_exc_code <= 2'd1;
                            r_state    <= S_EXC;
                        end else begin
                            r_state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (flush) begin
                        r_cancel <= 1'b1;
                    end
                    if (dresp_data_ok) begin
                        if (!r_store) begin
                            r_wb_data <= w_ext;
                        end
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        r_exc_code <= 2'd3;
                        r_state    <= S_EXC;
                    end else if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign dreq_valid  = w_bus;
    assign dreq_addr   = w_bus ? r_addr : '0;
    assign dreq_size   = w_bus ? {1'b0, r_funct3[1:0]} : 3'd0;
    assign dreq_strobe = w_bus ? r_strobe : '0;
    assign dreq_data   = w_bus ? r_sdata : '0;

    assign wb_valid  = (r_state == S_RESP) && !r_store && !r_cancel;
    assign wb_rd     = wb_valid ? r_rd : 5'd0;
    assign wb_data   = r_wb_data;
    assign done      = (r_state == S_RESP) || (r_state == S_EXC);
    assign exc_valid = (r_state == S_EXC);
    assign exc_code  = exc_valid ? r_exc_code : 2'd0;
    assign exc_addr  = exc_valid ? r_addr : '0;
endmodule

// File: tb/tb_dbus_lsu.sv
// Bench for dbus_lsu: directed and random operations against a byte-lane model,
// on an XLEN=64/TIMEOUT=8 instance and an XLEN=32/TIMEOUT=0 instance.
module tb_dbus_lsu;
    logic        clk;
    logic        rst;
    logic        rv64, rv32;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        sel32;

    logic        d64_req_ready, d64_dreq_valid, d64_wb_valid, d64_done, d64_exc_valid;
    logic [63:0] d64_dreq_addr, d64_dreq_data, d64_wb_data, d64_exc_addr;
    logic [2:0]  d64_dreq_size;
    logic [7:0]  d64_dreq_strobe;
    logic [4:0]  d64_wb_rd;
    logic [1:0]  d64_exc_code;

    logic        d32_req_ready, d32_dreq_valid, d32_wb_valid, d32_done, d32_exc_valid;
    logic [31:0] d32_dreq_addr, d32_dreq_data, d32_wb_data, d32_exc_addr;
    logic [2:0]  d32_dreq_size;
    logic [3:0]  d32_dreq_strobe;
    logic [4:0]  d32_wb_rd;
    logic [1:0]  d32_exc_code;

    logic        m_req_ready, m_dreq_valid, m_wb_valid, m_done, m_exc_valid;
    logic [63:0] m_dreq_addr, m_dreq_data, m_wb_data, m_exc_addr;
    logic [2:0]  m_dreq_size;
    logic [7:0]  m_dreq_strobe;
    logic [4:0]  m_wb_rd;
    logic [1:0]  m_exc_code;

    int n_chk = 0;
    int n_err = 0;

    dbus_lsu #(.XLEN(64), .AW(64), .TIMEOUT(8)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(d64_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
        .dreq_valid(d64_dreq_valid), .dreq_addr(d64_dreq_addr), .dreq_size(d64_dreq_size),
        .dreq_strobe(d64_dreq_strobe), .dreq_data(d64_dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .wb_valid(d64_wb_valid), .wb_rd(d64_wb_rd), .wb_data(d64_wb_data),
        .done(d64_done), .exc_valid(d64_exc_valid), .exc_code(d64_exc_code),
        .exc_addr(d64_exc_addr)
    );

    dbus_lsu #(.XLEN(32), .AW(32), .TIMEOUT(0)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(d32_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .req_rd(req_rd), .flush(flush),
        .dreq_valid(d32_dreq_valid), .dreq_addr(d32_dreq_addr), .dreq_size(d32_dreq_size),
        .dreq_strobe(d32_dreq_strobe), .dreq_data(d32_dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data[31:0]),
        .wb_valid(d32_wb_valid), .wb_rd(d32_wb_rd), .wb_data(d32_wb_data),
        .done(d32_done), .exc_valid(d32_exc_valid), .exc_code(d32_exc_code),
        .exc_addr(d32_exc_addr)
    );

    assign m_req_ready   = sel32 ? d32_req_ready : d64_req_ready;
    assign m_dreq_valid  = sel32 ? d32_dreq_valid : d64_dreq_valid;
    assign m_dreq_addr   = sel32 ? {32'b0, d32_dreq_addr} : d64_dreq_addr;
    assign m_dreq_size   = sel32 ? d32_dreq_size : d64_dreq_size;
    assign m_dreq_strobe = sel32 ? {4'b0, d32_dreq_strobe} : d64_dreq_strobe;
    assign m_dreq_data   = sel32 ? {32'b0, d32_dreq_data} : d64_dreq_data;
    assign m_wb_valid    = sel32 ? d32_wb_valid : d64_wb_valid;
    assign m_wb_rd       = sel32 ? d32_wb_rd : d64_wb_rd;
    assign m_wb_data     = sel32 ? {32'b0, d32_wb_data} : d64_wb_data;
    assign m_done        = sel32 ? d32_done : d64_done;
    assign m_exc_valid   = sel32 ? d32_exc_valid : d64_exc_valid;
    assign m_exc_code    = sel32 ? d32_exc_code : d64_exc_code;
    assign m_exc_addr    = sel32 ? {32'b0, d32_exc_addr} : d64_exc_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-lane reference: expected fault code, store lanes and extended load value.
    task automatic model(input int xl, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, output logic [1:0] code,
                         output logic [7:0] strb, output logic [63:0] sdata,
                         output logic [63:0] ldata);
        int nb;
        int off;
        logic [63:0] xmask;
        logic [63:0] vmask;
        nb    = 1 << f3[1:0];
        off   = int'(addr % 64'(xl / 8));
        xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        code  = 2'd0;
        if ((st && f3[2]) || f3 == 3'b111 || (xl == 32 && (nb == 8 || f3 == 3'b110)))
            code = 2'd2;
        else if (addr % 64'(nb) != 0)
            code = 2'd1;
        strb  = 8'(((1 << nb) - 1) << off);
        sdata = (wdata << (8 * off)) & xmask;
        vmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        ldata = (rdata >> (8 * off)) & vmask;
        if (!f3[2] && ldata[8 * nb - 1])
            ldata = ldata | ~vmask;
        ldata = ldata & xmask;
    endtask

    // dly: BUS cycle (1-based) carrying data_ok; beyond the timeout it never arrives.
    // flush_at: -1 none, 0 accept cycle, k = k-th BUS cycle.
    task automatic do_op(input bit x32, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic [4:0] rd,
                         input int dly, input int flush_at);
        int xl;
        int to;
        int ncyc;
        bit exp_wb;
        logic [1:0] code;
        logic [7:0] strb;
        logic [63:0] sdata, ldata;
        xl = x32 ? 32 : 64;
        to = x32 ? 0 : 8;
        model(xl, st, f3, addr, wdata, rdata, code, strb, sdata, ldata);
        if (code != 2'd0) ncyc = 0;
        else if (dly >= 1 && (to == 0 || dly <= to)) ncyc = dly;
        else begin
            ncyc = to;
            code = 2'd3;
        end
        exp_wb = (code == 2'd0) && !st && !(flush_at >= 0 && flush_at <= ncyc);

        sel32      = x32;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        rv32       = x32;
        rv64       = !x32;
        flush      = (flush_at == 0);
        @(negedge clk);
        chk("req_ready_idle", m_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rv32 = 1'b0;
        rv64 = 1'b0;
        flush = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_funct3 = 3'($urandom);
        for (int k = 1; k <= ncyc; k++) begin
            dresp_data_ok = (k == dly);
            dresp_data    = (k == dly) ? rdata : {$urandom, $urandom};
            flush         = (k == flush_at);
            @(negedge clk);
            chk("dreq_valid", m_dreq_valid, 1'b1);
            chk("req_ready_bus", m_req_ready, 1'b0);
            chk("dreq_addr", m_dreq_addr, addr);
            chk("dreq_size", m_dreq_size, {1'b0, f3[1:0]});
            chk("dreq_strobe", m_dreq_strobe, st ? strb : 8'h00);
            if (st) chk("dreq_data", m_dreq_data, sdata);
            chk("done_bus", m_done, 1'b0);
            @(posedge clk);
            #1;
            dresp_data_ok = 1'b0;
            flush = 1'b0;
        end
        @(negedge clk);
        chk("done", m_done, 1'b1);
        chk("exc_valid", m_exc_valid, code != 2'd0);
        chk("exc_code", m_exc_code, code);
        chk("exc_addr", m_exc_addr, (code != 2'd0) ? addr : 64'd0);
        chk("dreq_valid_end", m_dreq_valid, 1'b0);
        chk("req_ready_end", m_req_ready, 1'b0);
        chk("wb_valid", m_wb_valid, exp_wb);
        if (exp_wb) begin
            chk("wb_data", m_wb_data, ldata);
            chk("wb_rd", m_wb_rd, rd);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_after", m_done, 1'b0);
        chk("wb_valid_after", m_wb_valid, 1'b0);
        chk("req_ready_after", m_req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit x32;
        logic st;
        logic [2:0] f3;
        logic [63:0] a;
        int dly;
        int fa;

        rst = 1'b1; rv64 = 0; rv32 = 0; req_store = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; req_rd = 0; flush = 0; dresp_data_ok = 0; dresp_data = 0; sel32 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", m_req_ready, 1'b1);
        chk("rst_dreq_valid", m_dreq_valid, 1'b0);
        chk("rst_dreq_strobe", m_dreq_strobe, 8'h00);
        chk("rst_done", m_done, 1'b0);
        chk("rst_wb_valid", m_wb_valid, 1'b0);
        chk("rst_wb_data", m_wb_data, 64'd0);
        chk("rst_exc_valid", m_exc_valid, 1'b0);
        chk("rst32_req_ready", d32_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(0, 0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 3, -1);
        do_op(0, 0, 3'b100, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd8, 3, -1);
        do_op(0, 1, 3'b001, 64'h1006, 64'hBEEF, 64'h0, 5'd0, 2, -1);
        do_op(0, 0, 3'b010, 64'h1002, 64'h0, 64'h0, 5'd3, 1, -1);
        do_op(0, 0, 3'b011, 64'h2000, 64'h0, 64'h8123_4567_89AB_CDEF, 5'd9, 4, -1);
        do_op(0, 0, 3'b010, 64'h3000, 64'h0, 64'h1, 5'd4, 9, -1);
        do_op(0, 0, 3'b010, 64'h3004, 64'h0, 64'hF000_0001_0000_0000, 5'd4, 8, -1);
        do_op(0, 0, 3'b001, 64'h4002, 64'h0, 64'h0000_0000_1234_0000, 5'd5, 4, 2);
        do_op(0, 0, 3'b000, 64'h4001, 64'h0, 64'h0, 5'd5, 2, 0);
        do_op(0, 0, 3'b000, 64'h4001, 64'h0, 64'h0, 5'd5, 2, 2);
        do_op(0, 1, 3'b110, 64'h4000, 64'h0, 64'h0, 5'd0, 1, -1);
        do_op(1, 0, 3'b011, 64'h2000, 64'h0, 64'h0, 5'd1, 2, -1);
        do_op(1, 0, 3'b110, 64'h2000, 64'h0, 64'h0, 5'd1, 2, -1);
        do_op(1, 0, 3'b001, 64'h0102, 64'h0, 64'h8001_0000, 5'd2, 2, -1);
        do_op(1, 1, 3'b000, 64'h0003, 64'hA5, 64'h0, 5'd0, 1, -1);

        // Reset while the bus request is outstanding.
        sel32 = 0; req_store = 0; req_funct3 = 3'b011; req_addr = 64'h5000; req_rd = 5'd6;
        rv64 = 1;
        @(posedge clk);
        #1;
        rv64 = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_bus_valid", m_dreq_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_dreq_valid", m_dreq_valid, 1'b0);
        chk("rst_mid_dreq_addr", m_dreq_addr, 64'd0);
        chk("rst_mid_done", m_done, 1'b0);
        chk("rst_mid_wb_valid", m_wb_valid, 1'b0);
        chk("rst_mid_req_ready", m_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(0, 0, 3'b010, 64'h6004, 64'h0, 64'h7FFF_FFFF_0000_0000, 5'd11, 2, -1);

        for (int i = 0; i < 200; i++) begin
            x32 = ($urandom % 4 == 0);
            st  = 1'($urandom);
            f3  = 3'($urandom);
            a   = {$urandom, $urandom};
            if (x32) a[63:32] = 32'd0;
            if ($urandom % 4 != 0) a = a & ~(64'((1 << f3[1:0]) - 1));
            if (x32) dly = int'($urandom_range(1, 6));
            else if ($urandom % 6 == 0) dly = 9;
            else dly = int'($urandom_range(1, 8));
            fa = ($urandom % 5 == 0) ? int'($urandom_range(0, dly)) : -1;
            if ($urandom % 8 == 0) begin
                sel32 = x32;
                dresp_data_ok = 1'b1;
                @(negedge clk);
                chk("idle_dok_done", m_done, 1'b0);
                chk("idle_dok_wb", m_wb_valid, 1'b0);
                @(posedge clk);
                #1;
                dresp_data_ok = 1'b0;
            end
            do_op(x32, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), dly, fa);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
